// File: rtl/program_monitor.sv
// Program-run monitor: watches a CPU's PC and data stores, detects end of program
// (stalled PC or tohost store) or timeout, then grades per-channel results.
module program_monitor #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned HALT_STABLE = 4,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [31:0]          rom_addr_i,
    input  logic                 mem_wr_sig_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [31:0]          mem_wr_data_i,
    input  logic [N_CH*32-1:0]   obs_value_i,
    input  logic [N_CH*32-1:0]   exp_value_i,
    input  logic [N_CH-1:0]      ch_en_i,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [N_CH-1:0]      fail_mask_o,
    output logic [31:0]          cycle_count_o,
    output logic [31:0]          tohost_code_o
);

    typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       stable_q, stable_d;
    logic [31:0]       prev_pc_q, prev_pc_d;
    logic              first_q, first_d;
    logic [N_CH-1:0]   fail_mask_q, fail_mask_d;
    logic [31:0]       tohost_code_q, tohost_code_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic              pc_eq, pc_halt, tohost_hit, halt, tmo;
    logic [31:0]       cnt_inc;
    logic [N_CH-1:0]   mismatch;

    always_comb begin
        // prev_pc holds no valid sample in the first RUN cycle
        pc_eq      = !first_q && (rom_addr_i == prev_pc_q);
        pc_halt    = pc_eq && (stable_q == 32'(HALT_STABLE - 1));
        tohost_hit = mem_wr_sig_i && (mem_addr_i == TOHOST_ADDR);
        halt       = pc_halt || tohost_hit;
        cnt_inc    = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
        tmo        = cnt_inc >= 32'(TIMEOUT);
        for (int i = 0; i < int'(N_CH); i++) begin
            mismatch[i] = ch_en_i[i] && (obs_value_i[32*i +: 32] != exp_value_i[32*i +: 32]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (halt) begin
                        state_d = StCheck;
                    end else if (tmo) begin
                        state_d = StDone;
                    end
                end
                StCheck: state_d = StDone;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        stable_d      = stable_q;
        prev_pc_d     = prev_pc_q;
        first_d       = first_q;
        fail_mask_d   = fail_mask_q;
        tohost_code_d = tohost_code_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        if (start_i) begin
            cycle_count_d = '0;
            stable_d      = '0;
            prev_pc_d     = '0;
            first_d       = 1'b1;
            fail_mask_d   = '0;
            tohost_code_d = '0;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            timeout_d     = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    cycle_count_d = cnt_inc;
                    prev_pc_d     = rom_addr_i;
                    stable_d      = pc_eq ? stable_q + 32'd1 : '0;
                    first_d       = 1'b0;
                    if (tohost_hit) begin
                        tohost_code_d = mem_wr_data_i;
                    end
                    if (!halt && tmo) begin
                        done_d      = 1'b1;
                        timeout_d   = 1'b1;
                        pass_d      = 1'b0;
                        fail_mask_d = '0;
                    end
                end
                StCheck: begin
                    fail_mask_d = mismatch;
                    done_d      = 1'b1;
                    pass_d      = (mismatch == '0) && (tohost_code_q == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cycle_count_q <= '0;
            stable_q      <= '0;
            prev_pc_q     <= '0;
            first_q       <= 1'b0;
            fail_mask_q   <= '0;
            tohost_code_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            cycle_count_q <= cycle_count_d;
            stable_q      <= stable_d;
            prev_pc_q     <= prev_pc_d;
            first_q       <= first_d;
            fail_mask_q   <= fail_mask_d;
            tohost_code_q <= tohost_code_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        done_o        = done_q;
        pass_o        = pass_q;
        timeout_o     = timeout_q;
        fail_mask_o   = fail_mask_q;
        cycle_count_o = cycle_count_q;
        tohost_code_o = tohost_code_q;
    end

endmodule

// File: tb/tb_program_monitor.sv
// Directed bench for program_monitor: PC halt, mismatch, tohost, timeout, reset and restart.
module tb_program_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] rom_addr;
    logic        mem_wr_sig;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] obs0, obs1, exp0, exp1;
    logic [1:0]  ch_en;
    logic        done, pass, timeout;
    logic [1:0]  fail_mask;
    logic [31:0] cycle_count, tohost_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_monitor #(
        .N_CH        (2),
        .TIMEOUT     (50),
        .HALT_STABLE (4),
        .TOHOST_ADDR (32'h0000_0FFC)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .start_i       (start),
        .rom_addr_i    (rom_addr),
        .mem_wr_sig_i  (mem_wr_sig),
        .mem_addr_i    (mem_addr),
        .mem_wr_data_i (mem_wr_data),
        .obs_value_i   ({obs1, obs0}),
        .exp_value_i   ({exp1, exp0}),
        .ch_en_i       (ch_en),
        .done_o        (done),
        .pass_o        (pass),
        .timeout_o     (timeout),
        .fail_mask_o   (fail_mask),
        .cycle_count_o (cycle_count),
        .tohost_code_o (tohost_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // PC 0,4,8 then 12 held; the 4th equal sample lands in RUN cycle 8.
    task automatic pc_hold_run();
        rom_addr = 32'd0;  step();
        rom_addr = 32'd4;  step();
        rom_addr = 32'd8;  step();
        rom_addr = 32'd12;
        repeat (5) step();
    endtask

    task automatic tohost_run(input logic [31:0] code);
        for (int c = 1; c <= 20; c++) begin
            rom_addr    = 32'(4 * c);
            mem_wr_sig  = (c == 10) || (c == 20);
            mem_addr    = (c == 20) ? 32'h0000_0FFC : 32'h0000_0FF8;
            mem_wr_data = (c == 20) ? code : 32'hDEAD_BEEF;
            step();
        end
        mem_wr_sig = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_tmo"}, 32'(timeout), 32'd0);
        check({tag, "_fail"}, 32'(fail_mask), 32'd0);
        check({tag, "_cc"}, cycle_count, 32'd0);
        check({tag, "_code"}, tohost_code, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; rom_addr = '0;
        mem_wr_sig = 1'b0; mem_addr = '0; mem_wr_data = '0;
        obs0 = 32'd55; obs1 = 32'd55; exp0 = 32'd55; exp1 = 32'd55; ch_en = 2'b11;
        repeat (2) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_cc", cycle_count, 32'd0);

        // PC halt with matching results
        pulse_start();
        pc_hold_run();
        check("pch_k1_done", 32'(done), 32'd0);
        check("pch_k1_cc", cycle_count, 32'd8);
        step();
        check("pch_done", 32'(done), 32'd1);
        check("pch_pass", 32'(pass), 32'd1);
        check("pch_fail", 32'(fail_mask), 32'd0);
        check("pch_tmo", 32'(timeout), 32'd0);
        rom_addr = 32'd100;
        repeat (3) step();
        check("pch_cc_frozen", cycle_count, 32'd8);
        check("pch_done_hold", 32'(done), 32'd1);

        // Mismatch on channel 1, restarted from DONE
        obs1 = 32'd54;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_done_clr", 32'(done), 32'd0);
        check("rst_cc_clr", cycle_count, 32'd0);
        pc_hold_run();
        step();
        check("mm_done", 32'(done), 32'd1);
        check("mm_fail", 32'(fail_mask), 32'd2);
        check("mm_pass", 32'(pass), 32'd0);
        check("mm_cc", cycle_count, 32'd8);

        // Mismatch masked by channel enables
        ch_en = 2'b01;
        pulse_start(); pc_hold_run(); step();
        check("msk1_fail", 32'(fail_mask), 32'd0);
        check("msk1_pass", 32'(pass), 32'd1);
        ch_en = 2'b00; obs0 = 32'd1;
        pulse_start(); pc_hold_run(); step();
        check("msk0_pass", 32'(pass), 32'd1);
        check("msk0_done", 32'(done), 32'd1);
        obs0 = 32'd55; obs1 = 32'd55; ch_en = 2'b11;

        // tohost halt, nonzero code; the write to 0xFF8 must be ignored
        pulse_start();
        tohost_run(32'h0000_0003);
        check("th_k1_done", 32'(done), 32'd0);
        check("th_code", tohost_code, 32'd3);
        step();
        check("th_done", 32'(done), 32'd1);
        check("th_pass", 32'(pass), 32'd0);
        check("th_cc", cycle_count, 32'd20);
        check("th_tmo", 32'(timeout), 32'd0);
        pulse_start();
        tohost_run(32'h0000_0000);
        step();
        check("th0_done", 32'(done), 32'd1);
        check("th0_pass", 32'(pass), 32'd1);
        check("th0_code", tohost_code, 32'd0);

        // Timeout with PC always moving
        pulse_start();
        for (int c = 1; c <= 49; c++) begin
            rom_addr = 32'(4 * c);
            step();
        end
        check("tmo_pre_done", 32'(done), 32'd0);
        rom_addr = 32'd200;
        step();
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_pass", 32'(pass), 32'd0);
        check("tmo_fail", 32'(fail_mask), 32'd0);
        check("tmo_cc", cycle_count, 32'd50);
        repeat (3) begin rom_addr = rom_addr + 32'd4; step(); end
        check("tmo_cc_frozen", cycle_count, 32'd50);

        // Halt in the timeout cycle wins over timeout
        pulse_start();
        for (int c = 1; c <= 49; c++) begin
            rom_addr = 32'(4 * c);
            step();
        end
        rom_addr = 32'd200; mem_wr_sig = 1'b1; mem_addr = 32'h0000_0FFC; mem_wr_data = '0;
        step();
        mem_wr_sig = 1'b0;
        check("tmh_k1_done", 32'(done), 32'd0);
        check("tmh_k1_tmo", 32'(timeout), 32'd0);
        step();
        check("tmh_done", 32'(done), 32'd1);
        check("tmh_tmo", 32'(timeout), 32'd0);
        check("tmh_pass", 32'(pass), 32'd1);
        check("tmh_cc", cycle_count, 32'd50);

        // Restart while in RUN, then a clean PC-halt run
        obs1 = 32'd54;
        pulse_start();
        for (int c = 1; c <= 30; c++) begin
            rom_addr = 32'(4 * c);
            step();
        end
        check("rr_cc_pre", cycle_count, 32'd30);
        obs1 = 32'd55;
        pulse_start();
        check("rr_cc_clr", cycle_count, 32'd0);
        pc_hold_run(); step();
        check("rr_done", 32'(done), 32'd1);
        check("rr_pass", 32'(pass), 32'd1);
        check("rr_cc", cycle_count, 32'd8);

        // Asynchronous reset mid-run
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            rom_addr = 32'(4 * c);
            step();
        end
        check("rm_cc_pre", cycle_count, 32'd10);
        #3 reset_n = 1'b0;
        #1 check_all_zero("rm");
        #1 reset_n = 1'b1;
        rom_addr = 32'd64;
        repeat (10) step();
        check("rm_idle_done", 32'(done), 32'd0);
        check("rm_idle_cc", cycle_count, 32'd0);

        // Asynchronous reset from DONE with nonzero outputs
        obs1 = 32'd54;
        pulse_start(); pc_hold_run(); step();
        check("rd_fail_pre", 32'(fail_mask), 32'd2);
        #2 reset_n = 1'b0;
        #1 check_all_zero("rd");
        #1 reset_n = 1'b1;
        repeat (3) step();
        check("rd_idle_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
